// File: rtl/fast_square_bb_comb_sweep.sv
`default_nettype none
// ============================================================================
// Module      : fast_square_bb_comb_sweep
// Description : Coherent I/Q baseband averager with an automatic frequency-step
//               sweep. Each step discards SETTLE_CYCLES samples, then averages
//               2^ACC_LOG2 samples and emits one I/Q pair with a strobe.
// Ports       : clock           - system clock, one sample per cycle
//               reset           - asynchronous active-low reset
//               record          - level, enables sweep/accumulation
//               freq_step       - pulse, forces early advance to next step
//               i_in / q_in     - signed baseband samples
//               i_out / q_out   - signed averages, held between strobes
//               data_out_strobe - pulse, i_out/q_out/step_idx valid
//               step_idx        - step index of current/last result
//               sweep_done      - pulse with the strobe of the final step
//               busy            - high while settling or accumulating
// Revision    : 1.0 - initial release
// ============================================================================
module fast_square_bb_comb_sweep #(
    parameter int WIDTH         = 16,
    parameter int ACC_LOG2      = 4,
    parameter int NUM_STEPS     = 8,
    parameter int SETTLE_CYCLES = 4,
    localparam int SW           = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    record,
    input  logic                    freq_step,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    data_out_strobe,
    output logic [SW-1:0]           step_idx,
    output logic                    sweep_done,
    output logic                    busy
);

    localparam int AW = WIDTH + ACC_LOG2;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_ACCUM  = 2'd2;

    // With no settle interval a new step begins accumulating immediately.
    localparam logic [1:0] c_ENTER = (SETTLE_CYCLES == 0) ? c_ACCUM : c_SETTLE;

    localparam logic [CW-1:0] c_SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [SW-1:0] c_STEP_LAST   = SW'(NUM_STEPS - 1);

    logic [1:0]           r_state;
    logic signed [AW-1:0] r_acc_i;
    logic signed [AW-1:0] r_acc_q;
    logic [ACC_LOG2-1:0]  r_cnt;
    logic [CW-1:0]        r_settle;
    logic [SW-1:0]        r_step;

    logic signed [AW-1:0] w_sum_i;
    logic signed [AW-1:0] w_sum_q;
    logic                 w_last;
    logic [SW-1:0]        w_step_next;

    // Accumulator is wide enough for 2^ACC_LOG2 full-scale samples.
    assign w_sum_i     = r_acc_i + {{ACC_LOG2{i_in[WIDTH-1]}}, i_in};
    assign w_sum_q     = r_acc_q + {{ACC_LOG2{q_in[WIDTH-1]}}, q_in};
    assign w_last      = &r_cnt;
    assign w_step_next = (r_step == c_STEP_LAST) ? '0 : r_step + 1'b1;
    assign busy        = (r_state != c_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= c_IDLE;
            r_acc_i         <= '0;
            r_acc_q         <= '0;
            r_cnt           <= '0;
            r_settle        <= '0;
            r_step          <= '0;
            i_out           <= '0;
            q_out           <= '0;
            data_out_strobe <= 1'b0;
            sweep_done      <= 1'b0;
            step_idx        <= '0;
        end else begin
            data_out_strobe <= 1'b0;
            sweep_done      <= 1'b0;
            // The visible index trails the internal step by one cycle so the
            // strobe cycle still shows the index of the result being emitted.
            step_idx        <= r_step;

            case (r_state)
                c_IDLE: begin
                    if (record) begin
                        r_step   <= '0;
                        step_idx <= '0;
                        r_acc_i  <= '0;
                        r_acc_q  <= '0;
                        r_cnt    <= '0;
                        r_settle <= '0;
                        r_state  <= c_ENTER;
                    end
                end

                c_SETTLE: begin
                    if (!record) begin
                        r_settle <= '0;
                        r_state  <= c_IDLE;
                    end else if (freq_step) begin
                        r_step   <= w_step_next;
                        r_settle <= '0;
                    end else if (r_settle == c_SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= c_ACCUM;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end

                c_ACCUM: begin
                    if (w_last) begin
                        // The dump wins over abort/advance requests, so a
                        // freq_step here yields exactly one step advance.
                        i_out           <= w_sum_i[ACC_LOG2 +: WIDTH];
                        q_out           <= w_sum_q[ACC_LOG2 +: WIDTH];
                        data_out_strobe <= 1'b1;
                        sweep_done      <= (r_step == c_STEP_LAST);
                        r_step          <= w_step_next;
                        r_acc_i         <= '0;
                        r_acc_q         <= '0;
                        r_cnt           <= '0;
                        r_state         <= record ? c_ENTER : c_IDLE;
                    end else if (!record) begin
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else if (freq_step) begin
                        r_step  <= w_step_next;
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ENTER;
                    end else begin
                        r_acc_i <= w_sum_i;
                        r_acc_q <= w_sum_q;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fast_square_bb_comb_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_fast_square_bb_comb_sweep
// Description : Self-checking bench for fast_square_bb_comb_sweep with
//               WIDTH=16, ACC_LOG2=2, NUM_STEPS=4, SETTLE_CYCLES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fast_square_bb_comb_sweep;

    localparam int W  = 16;
    localparam int AL = 2;
    localparam int NS = 4;
    localparam int ST = 2;
    localparam int N  = 1 << AL;
    localparam int L  = ST + N;   // samples per step window

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        record    = 1'b0;
    logic        freq_step = 1'b0;
    logic [15:0] i_in      = '0;
    logic [15:0] q_in      = '0;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        data_out_strobe;
    logic [1:0]  step_idx;
    logic        sweep_done;
    logic        busy;

    fast_square_bb_comb_sweep #(
        .WIDTH        (W),
        .ACC_LOG2     (AL),
        .NUM_STEPS    (NS),
        .SETTLE_CYCLES(ST)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .record         (record),
        .freq_step      (freq_step),
        .i_in           (i_in),
        .q_in           (q_in),
        .i_out          (i_out),
        .q_out          (q_out),
        .data_out_strobe(data_out_strobe),
        .step_idx       (step_idx),
        .sweep_done     (sweep_done),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // ---------------- behavioural model ----------------
    // One position counter per step window: positions 0..ST-1 are discarded,
    // ST..L-1 are summed, and position L-1 produces the result.
    bit          m_run;
    int          m_pos, m_si, m_sq, m_step, md_old, md_ti, md_tq;
    logic [15:0] e_i, e_q;
    logic        e_strobe, e_done, e_busy;
    logic [1:0]  e_step;

    initial begin
        m_run = 0; m_pos = 0; m_si = 0; m_sq = 0; m_step = 0;
        e_i = 0; e_q = 0; e_strobe = 0; e_done = 0; e_busy = 0; e_step = 0;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_run = 0; m_pos = 0; m_si = 0; m_sq = 0; m_step = 0;
                e_i = 0; e_q = 0; e_strobe = 0; e_done = 0; e_busy = 0; e_step = 0;
            end else begin
                md_old   = m_step;
                e_strobe = 0;
                e_done   = 0;
                e_step   = 2'(md_old);
                if (!m_run) begin
                    if (record) begin
                        m_run = 1; m_step = 0; m_pos = 0; m_si = 0; m_sq = 0;
                        e_step = 0;
                    end
                end else if (m_pos == L - 1) begin
                    md_ti    = m_si + int'($signed(i_in));
                    md_tq    = m_sq + int'($signed(q_in));
                    e_i      = 16'(fdiv(md_ti, N));
                    e_q      = 16'(fdiv(md_tq, N));
                    e_strobe = 1;
                    e_done   = (m_step == NS - 1);
                    m_step   = (m_step + 1) % NS;
                    m_pos = 0; m_si = 0; m_sq = 0;
                    if (!record) m_run = 0;
                end else if (!record) begin
                    m_run = 0; m_pos = 0; m_si = 0; m_sq = 0;
                end else if (freq_step) begin
                    m_step = (m_step + 1) % NS;
                    m_pos = 0; m_si = 0; m_sq = 0;
                end else begin
                    if (m_pos >= ST) begin
                        m_si += int'($signed(i_in));
                        m_sq += int'($signed(q_in));
                    end
                    m_pos++;
                end
                e_busy = m_run;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("m_i_out",  32'(i_out),           32'(e_i));
                chk("m_q_out",  32'(q_out),           32'(e_q));
                chk("m_strobe", 32'(data_out_strobe), 32'(e_strobe));
                chk("m_done",   32'(sweep_done),      32'(e_done));
                chk("m_step",   32'(step_idx),        32'(e_step));
                chk("m_busy",   32'(busy),            32'(e_busy));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic        s_strobe, s_done, s_busy;
    logic [15:0] s_i, s_q;
    logic [1:0]  s_step;

    // Starts just after a rising edge: drives inputs, samples at the falling
    // edge, returns just after the next rising edge.
    task automatic cyc(input logic [15:0] ii, input logic [15:0] qq,
                       input logic rec, input logic fs);
        i_in = ii; q_in = qq; record = rec; freq_step = fs;
        @(negedge clock);
        s_strobe = data_out_strobe; s_done = sweep_done; s_busy = busy;
        s_i = i_out; s_q = q_out; s_step = step_idx;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] neg_pat(input int k);
        if (k >= 3 && k <= 5) return 16'hFFFF;
        if (k == 6) return 16'hFFFE;
        if (k >= 9 && k <= 12) return 16'hFFFD;
        return 16'h0000;
    endfunction

    int got, n, st_k[$], st_s[$];

    initial begin
        // Reset with arbitrary inputs
        i_in = 16'h5A5A; q_in = 16'hA5A5; record = 1'b1; freq_step = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_i_out",  32'(i_out), 32'h0);
        chk("rst_q_out",  32'(q_out), 32'h0);
        chk("rst_strobe", 32'(data_out_strobe), 32'h0);
        chk("rst_step",   32'(step_idx), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1; record = 1'b0; freq_step = 1'b0; i_in = 0; q_in = 0;
        repeat (3) cyc(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("idle_busy", 32'(s_busy), 32'h0);

        // Basic average
        got = -1;
        for (int k = 0; k < 20; k++) begin
            cyc(16'h1000, (k % 2) ? 16'h0100 : 16'h0000, 1'b1, 1'b0);
            if (s_strobe) begin got = k; break; end
        end
        chk("basic_latency", 32'(got), 32'd7);
        chk("basic_i", 32'(s_i), 32'h1000);
        chk("basic_q", 32'(s_q), 32'h0080);
        chk("basic_step", 32'(s_step), 32'h0);
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        // Negative rounding toward -inf
        for (int k = 0; k < 14; k++) begin
            cyc(neg_pat(k), 16'h0000, 1'b1, 1'b0);
            if (k == 7) begin
                chk("neg_strobe0", 32'(s_strobe), 32'h1);
                chk("neg_i0", 32'(s_i), 32'hFFFE);
            end
            if (k == 13) begin
                chk("neg_strobe1", 32'(s_strobe), 32'h1);
                chk("neg_i1", 32'(s_i), 32'hFFFD);
                chk("neg_step1", 32'(s_step), 32'h1);
            end
        end
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        // Full sweep with wrap
        n = 0;
        for (int k = 0; k < 34; k++) begin
            cyc(16'(k), 16'h0010, 1'b1, 1'b0);
            if (s_strobe) begin
                if (n < 5) begin
                    chk("sweep_cycle", 32'(k), 32'(7 + 6 * n));
                    chk("sweep_step", 32'(s_step), 32'(n % NS));
                    chk("sweep_done", 32'(s_done), 32'(n == 3));
                end
                if (n == 0) chk("sweep_i0", 32'(s_i), 32'd4);
                n++;
            end
        end
        chk("sweep_count", 32'(n), 32'd5);
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        // Early advance mid-accumulation
        st_k.delete(); st_s.delete();
        for (int k = 0; k < 20; k++) begin
            cyc(16'h0040, 16'h0000, 1'b1, (k == 11));
            if (s_strobe) begin st_k.push_back(k); st_s.push_back(int'(s_step)); end
        end
        chk("early_count", 32'(st_k.size()), 32'd2);
        if (st_k.size() == 2) begin
            chk("early_k0", 32'(st_k[0]), 32'd7);
            chk("early_k1", 32'(st_k[1]), 32'd18);
            chk("early_s1", 32'(st_s[1]), 32'd2);
        end
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        // freq_step on the last-sample cycle
        for (int k = 0; k < 20; k++) begin
            cyc(16'h0123, 16'h0321, 1'b1, (k == 12));
            if (k == 13) begin
                chk("last_fs_strobe1", 32'(s_strobe), 32'h1);
                chk("last_fs_step1", 32'(s_step), 32'h1);
            end
            if (k == 19) begin
                chk("last_fs_strobe2", 32'(s_strobe), 32'h1);
                chk("last_fs_step2", 32'(s_step), 32'h2);
                chk("last_fs_i", 32'(s_i), 32'h0123);
            end
        end
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        // record=0 during ACCUM
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(16'h7FFF, 16'h8000, (k < 4), 1'b0);
            if (s_strobe) n++;
            if (k == 5) chk("abort_busy", 32'(s_busy), 32'h0);
        end
        chk("abort_nostrobe", 32'(n), 32'h0);
        chk("abort_hold_i", 32'(s_i), 32'h0123);
        chk("abort_hold_q", 32'(s_q), 32'h0321);

        // Asynchronous reset mid-ACCUM
        for (int k = 0; k < 5; k++) cyc(16'h0001, 16'h0002, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async_i", 32'(i_out), 32'h0);
        chk("async_q", 32'(q_out), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1; record = 1'b0;
        repeat (2) cyc(16'h0, 16'h0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fast_square_bb_comb_sweep.md
Name: fast_square_bb_comb_sweep

Overview:
- Parametrised successor to the fast-square baseband combiner.
- Coherently averages I/Q baseband samples over 2^ACC_LOG2 samples per frequency step.
- Steps through NUM_STEPS frequency bins automatically while recording, with a settle blanking interval after each step change.
- Sits between the baseband decimator and the host FIFO; data_out_strobe qualifies one averaged I/Q pair per step.

Parameters:
WIDTH, 16, signed sample width of i_in/q_in/i_out/q_out
ACC_LOG2, 4, log2 of samples averaged per step (1..12)
NUM_STEPS, 8, frequency steps per sweep (2..256)
SETTLE_CYCLES, 4, samples discarded after each step change (0 allowed)

Ports:
clock  input  1  system clock; one sample per cycle
reset  input  1  asynchronous, active-low reset (0 = reset)
record  input  1  level; high enables sweep/accumulation
freq_step  input  1  one-cycle pulse; force early advance to next step
i_in  input  WIDTH  signed I sample
q_in  input  WIDTH  signed Q sample
i_out  output  WIDTH  signed averaged I, held between strobes
q_out  output  WIDTH  signed averaged Q, held between strobes
data_out_strobe  output  1  one-cycle pulse; i_out/q_out/step_idx valid
step_idx  output  max(1,clog2(NUM_STEPS))  step index of current/last result
sweep_done  output  1  one-cycle pulse coincident with strobe of step NUM_STEPS-1
busy  output  1  high in SETTLE or ACCUM

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; accumulators, counters and step index 0.
- Accumulators are signed, WIDTH+ACC_LOG2 bits, with no overflow possible.
- Result = accumulator >>> ACC_LOG2, arithmetic shift, truncation toward -inf, low WIDTH bits.

States:
- IDLE: busy=0.
  - record=1 -> step_idx<=0, clear accumulators.
  - Go to SETTLE, or straight to ACCUM if SETTLE_CYCLES=0.
- SETTLE: discard SETTLE_CYCLES samples (counter), then ACCUM.
- ACCUM: add i_in/q_in each cycle; sample counter runs 0..2^ACC_LOG2-1.
  - On the edge absorbing the last sample: i_out/q_out <= (acc+sample)>>>ACC_LOG2 and data_out_strobe<=1.
  - Result is therefore valid the cycle after the last sample was presented.
  - On the same edge: step_idx<=step_idx+1, wrapping NUM_STEPS-1 -> 0.
  - sweep_done<=1 if the step just finished was NUM_STEPS-1.
  - Clear accumulators; go to SETTLE (or ACCUM if SETTLE_CYCLES=0).
- step_idx timing: the strobe cycle presents the index of the result, not the new step.
  - step_idx updates to the new step the cycle after the strobe.

Events:
- freq_step in SETTLE/ACCUM (not the last-sample cycle):
  - Abort the current accumulation; no strobe.
  - step_idx advances with wrap; no sweep_done.
  - Restart SETTLE.
- freq_step on the last-sample cycle: the dump completes normally; exactly one advance (never two).
- freq_step in IDLE: ignored.
- record=0 in any state: next edge -> IDLE, accumulators cleared, no strobe.
  - i_out/q_out/step_idx hold their last values.
- record=0 on the last-sample cycle: the strobe still fires, then IDLE.
- Strobes never occur back-to-back. Minimum spacing is 2^ACC_LOG2+SETTLE_CYCLES cycles.

Test Plan:
- Reset check (WIDTH=16, ACC_LOG2=2, NUM_STEPS=4, SETTLE_CYCLES=2, used for all scenarios): reset=0 with any inputs -> all outputs 0, busy=0; release, record=0 -> stays IDLE.
- Basic average: record=1, i_in=16'h1000 constant, q_in alternating 0000/0100.
  - Strobe 7 cycles after record rises (2 settle + 4 accum + 1).
  - i_out=16'h1000, q_out=16'h0080, step_idx=0.
- Negative rounding: i_in sequence -1,-1,-1,-2 in ACCUM -> i_out=16'hFFFE (sum -5 >>>2 = -2); constant -3 -> 16'hFFFD.
- Full sweep: record held high -> four strobes with step_idx 0,1,2,3 spaced 6 cycles.
  - sweep_done only with step 3; fifth strobe step_idx=0.
- Early advance: freq_step pulse after 2 ACCUM samples of step 1 -> no strobe; next strobe carries step_idx=2.
  - freq_step on the last-sample cycle -> strobe step 1, next step 2.
- Abort/reset mid-operation:
  - record=0 during ACCUM -> IDLE next cycle, no strobe, outputs hold.
  - reset=0 asserted mid-ACCUM (between edges) -> outputs 0 immediately.
